// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Brief    : Shared encodings, widths and defaults for the scan transfer block.
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] FULL_LEVEL_DEF   = 7'd100;
    localparam logic [7:0]       XFER_TIMEOUT_DEF = 8'd127;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN_A = 3'd1,
        ST_XFER_A = 3'd2,
        ST_SCAN_B = 3'd3,
        ST_XFER_B = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_xfer_ctrl_if
// Brief    : Host and dual-scanner signal bundle for the ping-pong controller.
// Revision : 1.0 - initial release
// ============================================================================
interface scan_xfer_ctrl_if;

    logic                         go;
    logic                         stop;
    logic                         rdy_a;
    logic                         rdy_b;
    logic                         second_a;
    logic                         second_b;
    logic [scan_pkg::CNT_W-1:0]   count_a;
    logic [scan_pkg::CNT_W-1:0]   count_b;
    logic                         start_scan_a;
    logic                         start_scan_b;
    logic                         transfer_a;
    logic                         transfer_b;
    logic                         standby_a;
    logic                         standby_b;
    logic [2:0]                   state;
    logic [scan_pkg::CNT_W-1:0]   xfer_cnt;
    logic [7:0]                   rounds;
    logic                         err;

    modport master (
        input  go, stop, rdy_a, rdy_b, second_a, second_b, count_a, count_b,
        output start_scan_a, start_scan_b, transfer_a, transfer_b,
               standby_a, standby_b, state, xfer_cnt, rounds, err
    );

    modport slave (
        output go, stop, rdy_a, rdy_b, second_a, second_b, count_a, count_b,
        input  start_scan_a, start_scan_b, transfer_a, transfer_b,
               standby_a, standby_b, state, xfer_cnt, rounds, err
    );

endinterface
`default_nettype wire

// File: rtl/drain_timer.sv
`default_nettype none
// ============================================================================
// Module   : drain_timer
// Brief    : 8-bit drain cycle counter; flags the last permitted drain cycle.
// Revision : 1.0 - initial release
// ============================================================================
module drain_timer
    import scan_pkg::*;
#(
    parameter logic [7:0] LIMIT = XFER_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // count holds the cycles already spent, so the LIMIT-th cycle is count == LIMIT-1
    assign timeout = enable && (({1'b0, count} + 9'd1) >= {1'b0, LIMIT});

endmodule
`default_nettype wire

// File: rtl/scan_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_xfer_ctrl
// Brief    : Ping-pong controller alternating scan and drain of two scanners.
// Revision : 1.0 - initial release
// ============================================================================
module scan_xfer_ctrl
    import scan_pkg::*;
#(
    parameter logic [CNT_W-1:0] FULL_LEVEL   = FULL_LEVEL_DEF,
    parameter logic [7:0]       XFER_TIMEOUT = XFER_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    scan_xfer_ctrl_if.master  bus
);

    state_t             cur_state;
    logic               start_scan_a;
    logic               start_scan_b;
    logic               transfer_a;
    logic               transfer_b;
    logic               standby_a;
    logic               standby_b;
    logic [CNT_W-1:0]   xfer_cnt;
    logic [CNT_W-1:0]   prev_count;
    logic [7:0]         rounds;
    logic               err;
    logic               stop_pend;
    logic               other_started;
    logic               in_xfer;
    logic               timeout;

    assign in_xfer = (cur_state == ST_XFER_A) || (cur_state == ST_XFER_B);

    drain_timer #(
        .LIMIT   (XFER_TIMEOUT)
    ) u_drain_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_xfer),
        .enable  (in_xfer),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state     <= ST_IDLE;
            start_scan_a  <= 1'b0;
            start_scan_b  <= 1'b0;
            transfer_a    <= 1'b0;
            transfer_b    <= 1'b0;
            standby_a     <= 1'b1;
            standby_b     <= 1'b1;
            xfer_cnt      <= '0;
            prev_count    <= '0;
            rounds        <= 8'd0;
            err           <= 1'b0;
            stop_pend     <= 1'b0;
            other_started <= 1'b0;
        end else begin
            start_scan_a <= 1'b0;
            start_scan_b <= 1'b0;
            if ((cur_state != ST_IDLE) && bus.stop) begin
                stop_pend <= 1'b1;
            end
            case (cur_state)
                ST_IDLE: begin
                    stop_pend  <= 1'b0;
                    transfer_a <= 1'b0;
                    transfer_b <= 1'b0;
                    standby_a  <= 1'b1;
                    standby_b  <= 1'b1;
                    if (bus.go && !bus.stop && !err) begin
                        cur_state     <= ST_SCAN_A;
                        start_scan_a  <= 1'b1;
                        standby_a     <= 1'b0;
                        other_started <= 1'b0;
                    end
                end
                // The partner scanner is started at most once per scan phase,
                // either early on second_x or, failing that, when the drain begins.
                ST_SCAN_A: begin
                    if ((bus.count_a >= FULL_LEVEL) && bus.rdy_a) begin
                        cur_state  <= ST_XFER_A;
                        transfer_a <= 1'b1;
                        prev_count <= bus.count_a;
                        xfer_cnt   <= '0;
                        if (!other_started) begin
                            start_scan_b  <= 1'b1;
                            standby_b     <= 1'b0;
                            other_started <= 1'b1;
                        end
                    end else if (bus.second_a && !other_started) begin
                        start_scan_b  <= 1'b1;
                        standby_b     <= 1'b0;
                        other_started <= 1'b1;
                    end
                end
                ST_XFER_A: begin
                    prev_count <= bus.count_a;
                    if (bus.count_a < prev_count) begin
                        xfer_cnt <= sat_inc(xfer_cnt);
                    end
                    if (bus.count_a == '0) begin
                        transfer_a <= 1'b0;
                        rounds     <= rounds + 8'd1;
                        xfer_cnt   <= '0;
                        if (stop_pend || bus.stop) begin
                            cur_state <= ST_HALT;
                            standby_a <= 1'b1;
                            standby_b <= 1'b1;
                        end else begin
                            cur_state     <= ST_SCAN_B;
                            other_started <= 1'b0;
                        end
                    end else if (timeout) begin
                        err        <= 1'b1;
                        transfer_a <= 1'b0;
                        cur_state  <= ST_HALT;
                        standby_a  <= 1'b1;
                        standby_b  <= 1'b1;
                    end
                end
                ST_SCAN_B: begin
                    if ((bus.count_b >= FULL_LEVEL) && bus.rdy_b) begin
                        cur_state  <= ST_XFER_B;
                        transfer_b <= 1'b1;
                        prev_count <= bus.count_b;
                        xfer_cnt   <= '0;
                        if (!other_started) begin
                            start_scan_a  <= 1'b1;
                            standby_a     <= 1'b0;
                            other_started <= 1'b1;
                        end
                    end else if (bus.second_b && !other_started) begin
                        start_scan_a  <= 1'b1;
                        standby_a     <= 1'b0;
                        other_started <= 1'b1;
                    end
                end
                ST_XFER_B: begin
                    prev_count <= bus.count_b;
                    if (bus.count_b < prev_count) begin
                        xfer_cnt <= sat_inc(xfer_cnt);
                    end
                    if (bus.count_b == '0) begin
                        transfer_b <= 1'b0;
                        rounds     <= rounds + 8'd1;
                        xfer_cnt   <= '0;
                        if (stop_pend || bus.stop) begin
                            cur_state <= ST_HALT;
                            standby_a <= 1'b1;
                            standby_b <= 1'b1;
                        end else begin
                            cur_state     <= ST_SCAN_A;
                            other_started <= 1'b0;
                        end
                    end else if (timeout) begin
                        err        <= 1'b1;
                        transfer_b <= 1'b0;
                        cur_state  <= ST_HALT;
                        standby_a  <= 1'b1;
                        standby_b  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    cur_state  <= ST_IDLE;
                    stop_pend  <= 1'b0;
                    transfer_a <= 1'b0;
                    transfer_b <= 1'b0;
                    standby_a  <= 1'b1;
                    standby_b  <= 1'b1;
                end
                default: begin
                    cur_state  <= ST_IDLE;
                    stop_pend  <= 1'b0;
                    transfer_a <= 1'b0;
                    transfer_b <= 1'b0;
                    standby_a  <= 1'b1;
                    standby_b  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state        = cur_state;
    assign bus.start_scan_a = start_scan_a;
    assign bus.start_scan_b = start_scan_b;
    assign bus.transfer_a   = transfer_a;
    assign bus.transfer_b   = transfer_b;
    assign bus.standby_a    = standby_a;
    assign bus.standby_b    = standby_b;
    assign bus.xfer_cnt     = xfer_cnt;
    assign bus.rounds       = rounds;
    assign bus.err          = err;

endmodule
`default_nettype wire

// File: tb/tb_scan_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_xfer_ctrl
// Brief    : Scoreboard bench with behavioural scanners for scan_xfer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_xfer_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scan_xfer_ctrl_if bus();

    scan_xfer_ctrl #(
        .FULL_LEVEL   (7'd100),
        .XFER_TIMEOUT (8'd127)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ssa;
        logic       ssb;
        logic       ta;
        logic       tb;
        logic       sa;
        logic       sb;
        logic       err;
        logic [7:0] rounds;
    } snap_t;

    snap_t      exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         ta_cycles = 0;
    int         tb_cycles = 0;
    int         start_pulses = 0;
    int         overlap_errs = 0;
    logic [2:0] prev_st = 3'd0;
    bit         freeze_a = 1'b0;
    logic [6:0] cnt_a = 7'd0;
    logic [6:0] cnt_b = 7'd0;
    bit         fill_a = 1'b0;
    bit         fill_b = 1'b0;

    function automatic snap_t mk(input int st, input bit ssa, input bit ssb, input bit ta,
                                 input bit tb, input bit sa, input bit sb, input bit er,
                                 input int r);
        snap_t s;
        s.st     = st[2:0];
        s.ssa    = ssa;
        s.ssb    = ssb;
        s.ta     = ta;
        s.tb     = tb;
        s.sa     = sa;
        s.sb     = sb;
        s.err    = er;
        s.rounds = r[7:0];
        return s;
    endfunction

    function automatic snap_t cur_snap();
        snap_t s;
        s.st     = bus.state;
        s.ssa    = bus.start_scan_a;
        s.ssb    = bus.start_scan_b;
        s.ta     = bus.transfer_a;
        s.tb     = bus.transfer_b;
        s.sa     = bus.standby_a;
        s.sb     = bus.standby_b;
        s.err    = bus.err;
        s.rounds = bus.rounds;
        return s;
    endfunction

    // Scanner models: fill one word per cycle after start, drain one per transfer cycle.
    always @(negedge clk) begin
        if (rst) begin
            cnt_a = 7'd0; fill_a = 1'b0;
            cnt_b = 7'd0; fill_b = 1'b0;
        end else begin
            if (bus.start_scan_a) begin
                fill_a = 1'b1; cnt_a = 7'd0;
            end else if (bus.transfer_a) begin
                fill_a = 1'b0;
                if (cnt_a != 7'd0 && !(freeze_a && cnt_a <= 7'd50)) cnt_a = cnt_a - 7'd1;
            end else if (fill_a && cnt_a < 7'd100) begin
                cnt_a = cnt_a + 7'd1;
            end
            if (bus.start_scan_b) begin
                fill_b = 1'b1; cnt_b = 7'd0;
            end else if (bus.transfer_b) begin
                fill_b = 1'b0;
                if (cnt_b != 7'd0) cnt_b = cnt_b - 7'd1;
            end else if (fill_b && cnt_b < 7'd100) begin
                cnt_b = cnt_b + 7'd1;
            end
        end
        bus.count_a  = cnt_a;
        bus.count_b  = cnt_b;
        bus.rdy_a    = (cnt_a >= 7'd100);
        bus.rdy_b    = (cnt_b >= 7'd100);
        bus.second_a = fill_a && (cnt_a >= 7'd90);
        bus.second_b = fill_b && (cnt_b >= 7'd90);
    end

    // Monitor: every state change or start pulse is matched against the queue.
    always @(negedge clk) begin
        snap_t s;
        snap_t e;
        s = cur_snap();
        if ((s.st != prev_st) || s.ssa || s.ssb) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event: unexpected got=%05h want=none", s);
            end else begin
                e = exp_q.pop_front();
                if (s !== e) begin
                    bad++;
                    $display("FAIL event: got=%05h want=%05h", s, e);
                end
            end
        end
        prev_st = s.st;
        if (bus.transfer_a) ta_cycles++;
        if (bus.transfer_b) tb_cycles++;
        if (bus.start_scan_a || bus.start_scan_b) start_pulses++;
        if ((bus.transfer_a && bus.transfer_b) || (bus.start_scan_a && bus.transfer_a) ||
            (bus.start_scan_b && bus.transfer_b)) overlap_errs++;
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_q_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        @(negedge clk);
        while (int'(bus.state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", int'(bus.state), st);
    endtask

    task automatic pulse_go();
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic push_scan_a_start();
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        bus.go = 1'b0;
        bus.stop = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;

        check("rst_state", int'(bus.state), 0);
        check("rst_standby", int'({bus.standby_a, bus.standby_b}), 3);
        check("rst_transfer", int'({bus.transfer_a, bus.transfer_b}), 0);
        check("rst_start", int'({bus.start_scan_a, bus.start_scan_b}), 0);
        check("rst_rounds", int'(bus.rounds), 0);
        check("rst_xfer_cnt", int'(bus.xfer_cnt), 0);
        check("rst_err", int'(bus.err), 0);

        // Two drains, stop raised during SCAN_B ends the session after the B drain.
        push_scan_a_start();
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(mk(4, 1, 0, 0, 1, 0, 0, 0, 1));
        exp_q.push_back(mk(5, 0, 0, 0, 0, 1, 1, 0, 2));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 2));
        ta_cycles = 0; tb_cycles = 0;
        pulse_go();
        wait_state(3, 400);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_q_empty(600);
        check("ta_cycles", ta_cycles, 100);
        check("tb_cycles", tb_cycles, 100);
        check("halt_rounds", int'(bus.rounds), 2);
        check("halt_standby", int'({bus.standby_a, bus.standby_b}), 3);

        // go together with stop is ignored in IDLE.
        do_reset();
        @(negedge clk); #1;
        start_pulses = 0;
        @(negedge clk);
        bus.go = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.go = 1'b0; bus.stop = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("gostop_state", int'(bus.state), 0);
        check("gostop_pulses", start_pulses, 0);

        // A drain that stalls at 50 words times out and locks out further go.
        freeze_a = 1'b1;
        push_scan_a_start();
        exp_q.push_back(mk(5, 0, 0, 0, 0, 1, 1, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0));
        ta_cycles = 0;
        pulse_go();
        wait_q_empty(600);
        check("timeout_ta_cycles", ta_cycles, 127);
        check("timeout_err", int'(bus.err), 1);
        check("timeout_transfer_a", int'(bus.transfer_a), 0);
        pulse_go();
        repeat (5) @(negedge clk);
        #1;
        check("err_blocks_go", int'(bus.state), 0);
        freeze_a = 1'b0;

        // Reset on the 40th drain cycle.
        do_reset();
        @(negedge clk); #1;
        check("reset_clears_err", int'(bus.err), 0);
        push_scan_a_start();
        ta_cycles = 0;
        pulse_go();
        begin
            int n = 0;
            while (ta_cycles < 40 && n < 400) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check("drain40_reached", ta_cycles, 40);
        check("drain40_xfer_cnt", int'(bus.xfer_cnt), 39);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        #1 rst = 1'b1;
        #1;
        check("async_transfer_a", int'(bus.transfer_a), 0);
        check("async_state", int'(bus.state), 0);
        check("async_standby", int'({bus.standby_a, bus.standby_b}), 3);
        check("async_rounds", int'(bus.rounds), 0);
        check("async_xfer_cnt", int'(bus.xfer_cnt), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        wait_q_empty(10);

        // 256 drains wrap the round counter.
        push_scan_a_start();
        for (int n = 1; n <= 256; n++) begin
            if (n % 2 == 1) begin
                exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, n % 256));
                exp_q.push_back(mk(4, 1, 0, 0, 1, 0, 0, 0, n % 256));
            end else begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, n % 256));
                exp_q.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, n % 256));
            end
        end
        pulse_go();
        wait_q_empty(30000);
        check("wrap_rounds", int'(bus.rounds), 0);
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        do_reset();
        wait_q_empty(10);

        check("no_overlap", overlap_errs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_xfer_ctrl.md
SCAN_XFER_CTRL -- requirements
Module: scan_xfer_ctrl

Interface
REQ-001 Parameter FULL_LEVEL, default 7'd100: buffer occupancy at which a scanner is drained.
REQ-002 Parameter XFER_TIMEOUT, default 8'd127: maximum cycles allowed for one drain.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 go  input  1  host request to start ping-pong scanning.
REQ-006 stop  input  1  host request to end the session after the current drain.
REQ-007 rdy_a, rdy_b  input  1 each  scanner ready_to_transfer flags.
REQ-008 second_a, second_b  input  1 each  scanner start_second_buffer flags.
REQ-009 count_a, count_b  input  7 each  scanner data_count values.
REQ-010 start_scan_a, start_scan_b  output  1 each  one-cycle start pulse to a scanner.
REQ-011 transfer_a, transfer_b  output  1 each  level drain command to a scanner.
REQ-012 standby_a, standby_b  output  1 each  go_to_standby level to a scanner.
REQ-013 state  output  3  current FSM state.
REQ-014 xfer_cnt  output  7  words drained in the current round, saturating at 127.
REQ-015 rounds  output  8  completed drains since reset, wraps 255->0.
REQ-016 err  output  1  sticky drain-timeout flag.

Function
REQ-017 States SHALL be IDLE=0, SCAN_A=1, XFER_A=2, SCAN_B=3, XFER_B=4, HALT=5; codes 6-7 return to IDLE next cycle.
REQ-018 All outputs SHALL be registered; output changes appear one cycle after the causing input.
REQ-019 IDLE: standby_a=standby_b=1; on go && !stop && !err: pulse start_scan_a, enter SCAN_A; go && stop together: remain IDLE.
REQ-020 SCAN_A: standby_a=0; on first cycle with second_a=1, pulse start_scan_b exactly once per round (armed flag cleared on entry to SCAN_A).
REQ-021 SCAN_A -> XFER_A when count_a >= FULL_LEVEL && rdy_a; if second_a was never seen, pulse start_scan_b on that transition.
REQ-022 XFER_A: transfer_a=1; xfer_cnt increments each cycle count_a decreases; exit when count_a==0.
REQ-023 XFER_A exit: rounds+1, xfer_cnt cleared; if stop pending -> HALT, else -> SCAN_B.
REQ-024 SCAN_B/XFER_B: mirror REQ-020..023 with a/b swapped; XFER_B exit -> SCAN_A (start_scan_a pulsed per REQ-020 mirror) or HALT.
REQ-025 stop SHALL be latched (stop_pend) in any non-IDLE state and cleared on entry to IDLE.
REQ-026 stop in SCAN_x SHALL not abort the scan; the block finishes that scan and its drain before HALT.
REQ-027 Drain timer counts cycles in XFER_x; reaching XFER_TIMEOUT with count_x!=0 sets err, drops transfer_x, enters HALT.
REQ-028 HALT: transfer_a=transfer_b=0, standby_a=standby_b=1 for one cycle, then IDLE.
REQ-029 err SHALL block go until reset; only rst clears it.
REQ-030 transfer_a and transfer_b SHALL never be 1 in the same cycle; start_scan_x SHALL never coincide with transfer_x.

Reset
REQ-031 rst SHALL immediately force state=IDLE, start_scan_*=0, transfer_*=0, standby_*=1, xfer_cnt=0, rounds=0, err=0, stop_pend=0, timer=0.
REQ-032 Reset asserted mid-drain SHALL drop transfer_x asynchronously; no completed round is counted.

Structure
REQ-033 Shared package scan_pkg SHALL hold state encodings, FULL_LEVEL and XFER_TIMEOUT defaults, and the 7-bit count width.
REQ-034 One sub-module drain_timer (8-bit counter, clear/enable, timeout flag output) SHALL be instantiated.

Verification
REQ-035 go pulse, scanner model fills A to 100 -> start_scan_a pulse, start_scan_b once at count_a=90, transfer_a high 100 cycles, rounds=1, state=SCAN_B.
REQ-036 Two full rounds with stop asserted during SCAN_B -> XFER_B completes, HALT one cycle, IDLE, rounds=2, standby_a=standby_b=1.
REQ-037 go and stop same cycle in IDLE -> state stays 0, no start_scan pulse.
REQ-038 count_a held at 50 during XFER_A -> after 127 cycles err=1, transfer_a=0, IDLE; later go ignored.
REQ-039 rst asserted at XFER_A drain cycle 40 -> transfer_a=0 same cycle, all outputs at REQ-031 values, rounds=0.
REQ-040 256 drains -> rounds wraps to 0; transfer_a/transfer_b never overlap throughout.
